// File: rtl/uart_tx_fifo_if.sv
// Byte handshake bundle between the core-side producer and the UART-side consumer.
// The FIFO takes the slave view; the core/UART (or a testbench) takes the master view.
interface uart_tx_fifo_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through byte FIFO feeding the UART transmitter, with synchronous flush.
// Optional peak-occupancy tracking is enabled by defining UART_TX_FIFO_PEAK_EN.
module uart_tx_fifo #(
    parameter int DEPTH_LOG          = 4,
    parameter int ALMOST_FULL_MARGIN = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    uart_tx_fifo_if.slave        bus,
    output logic [DEPTH_LOG:0]   level,
    output logic                 almost_full,
    output logic                 empty
`ifdef UART_TX_FIFO_PEAK_EN
    ,
    input  logic                 peak_clear,
    output logic [DEPTH_LOG:0]   peak_level
`endif
);

    localparam int                 DEPTH     = 1 << DEPTH_LOG;
    localparam logic [DEPTH_LOG:0] DEPTH_L   = (DEPTH_LOG + 1)'(DEPTH);
    localparam logic [DEPTH_LOG:0] AF_MARGIN = (DEPTH_LOG + 1)'(ALMOST_FULL_MARGIN);

    logic [7:0]           mem_q [DEPTH];
    logic [DEPTH_LOG-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG:0]   level_q, level_d;
    logic                 in_ready;
    logic                 out_valid;
    logic                 push;
    logic                 pop;

    // Handshake flags come only from registered state, never from the peer's valid/ready.
    assign in_ready      = !reset && (level_q < DEPTH_L);
    assign out_valid     = (level_q != '0);
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_valid ? mem_q[rd_ptr_q] : 8'h00;

    assign push = bus.in_valid && in_ready;
    assign pop  = out_valid && bus.out_ready;

    assign level       = level_q;
    assign empty       = (level_q == '0);
    assign almost_full = ((DEPTH_L - level_q) <= AF_MARGIN);

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // NOTE: the storage array has no reset; stale entries are unreachable because level gates out_valid.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= bus.in_data;
        end
    end

`ifdef UART_TX_FIFO_PEAK_EN
    logic [DEPTH_LOG:0] peak_q, peak_d;

    always_comb begin
        peak_d = peak_q;
        if (flush) begin
            peak_d = '0;
        end else if (peak_clear) begin
            peak_d = level_q;
        end else if (level_d > peak_q) begin
            peak_d = level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak_level = peak_q;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: constant vector table, hand-written corner sequences,
// and a queue scoreboard that predicts every output each cycle.
module tb_uart_tx_fifo;

    localparam int DEPTH_LOG = 4;
    localparam int DEPTH     = 16;
    localparam int MARGIN    = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic [DEPTH_LOG:0] level;
    logic             almost_full;
    logic             empty;
`ifdef UART_TX_FIFO_PEAK_EN
    logic             peak_clear;
    logic [DEPTH_LOG:0] peak_level;
    int               m_peak;
`endif

    int errors = 0;
    int checks = 0;

    logic [7:0] sb [$];

    uart_tx_fifo_if bus_if ();

    uart_tx_fifo #(
        .DEPTH_LOG          (DEPTH_LOG),
        .ALMOST_FULL_MARGIN (MARGIN)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .bus         (bus_if),
        .level       (level),
        .almost_full (almost_full),
        .empty       (empty)
`ifdef UART_TX_FIFO_PEAK_EN
        ,
        .peak_clear  (peak_clear),
        .peak_level  (peak_level)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       in_valid;
        logic [7:0] in_data;
        logic       out_ready;
        logic       flush;
        int         exp_level;
        logic       exp_out_valid;
        logic [7:0] exp_out_data;
        logic       exp_in_ready;
        logic       exp_empty;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic r, input logic f);
        bus_if.in_valid  = v;
        bus_if.in_data   = d;
        bus_if.out_ready = r;
        flush            = f;
    endtask

    // One clock: check outputs against the queue model, update the model, advance past the edge.
    task automatic cycle();
        int   sz;
        logic exp_ir, exp_ov, do_push, do_pop;
        logic [7:0] exp_od;
        #1;
        sz     = sb.size();
        exp_ir = !reset && (sz < DEPTH);
        exp_ov = (sz != 0);
        exp_od = exp_ov ? sb[0] : 8'h00;
        check("in_ready",    32'(bus_if.in_ready),  32'(exp_ir));
        check("out_valid",   32'(bus_if.out_valid), 32'(exp_ov));
        check("out_data",    32'(bus_if.out_data),  32'(exp_od));
        check("level",       32'(level),            32'(sz));
        check("empty",       32'(empty),            32'(sz == 0));
        check("almost_full", 32'(almost_full),      32'((DEPTH - sz) <= MARGIN));
`ifdef UART_TX_FIFO_PEAK_EN
        check("peak_level",  32'(peak_level),       32'(m_peak));
`endif
        do_push = bus_if.in_valid && exp_ir;
        do_pop  = exp_ov && bus_if.out_ready;
        if (reset || flush) begin
            sb.delete();
        end else begin
            if (do_pop)  void'(sb.pop_front());
            if (do_push) sb.push_back(bus_if.in_data);
        end
`ifdef UART_TX_FIFO_PEAK_EN
        if (reset || flush)        m_peak = 0;
        else if (peak_clear)       m_peak = sz;
        else if (sb.size() > m_peak) m_peak = sb.size();
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic push_bytes(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, base + 8'(i), 1'b0, 1'b0);
            cycle();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic pop_bytes(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            cycle();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        // vec fields: valid, data, out_ready, flush | level, out_valid, out_data, in_ready, empty
        vecs[0] = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[1] = '{1'b1, 8'h41, 1'b0, 1'b0, 1, 1'b1, 8'h41, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b1, 8'h41, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 8'h42, 1'b1, 1'b0, 1, 1'b1, 8'h42, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 8'h43, 1'b1, 1'b0, 1, 1'b1, 8'h43, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[7] = '{1'b1, 8'h55, 1'b0, 1'b0, 1, 1'b1, 8'h55, 1'b1, 1'b0};
        vecs[8] = '{1'b1, 8'h66, 1'b1, 1'b1, 0, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b1, 1'b1};

        reset = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
`ifdef UART_TX_FIFO_PEAK_EN
        peak_clear = 1'b0;
        m_peak     = 0;
`endif
        @(posedge clk);
        #1;
        do_reset();

        // Basic push/pop, empty push-with-pop, simultaneous push+pop, flush.
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].in_valid, vecs[i].in_data, vecs[i].out_ready, vecs[i].flush);
            cycle();
            check($sformatf("vec%0d_level", i),     32'(level),            32'(vecs[i].exp_level));
            check($sformatf("vec%0d_out_valid", i), 32'(bus_if.out_valid), 32'(vecs[i].exp_out_valid));
            check($sformatf("vec%0d_out_data", i),  32'(bus_if.out_data),  32'(vecs[i].exp_out_data));
            check($sformatf("vec%0d_in_ready", i),  32'(bus_if.in_ready),  32'(vecs[i].exp_in_ready));
            check($sformatf("vec%0d_empty", i),     32'(empty),            32'(vecs[i].exp_empty));
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);

        // Fill to full, watch almost_full thresholds, push into full FIFO.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b0);
            cycle();
            if (i == 12) check("af_off_at_13", 32'(almost_full), 32'(0));
            if (i == 13) check("af_on_at_14",  32'(almost_full), 32'(1));
        end
        check("full_level",    32'(level),           32'(16));
        check("full_in_ready", 32'(bus_if.in_ready), 32'(0));
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'hFF, 1'b0, 1'b0);
            cycle();
        end
        check("full_hold_level", 32'(level), 32'(16));
        // Pop while full with in_valid held: no push this edge, in_ready rises next cycle.
        drive(1'b1, 8'hFE, 1'b1, 1'b0);
        cycle();
        check("full_pop_level", 32'(level),           32'(15));
        check("full_pop_ready", 32'(bus_if.in_ready), 32'(1));
        check("full_pop_head",  32'(bus_if.out_data), 32'(8'h01));
        pop_bytes(15);
        check("drained_empty", 32'(empty), 32'(1));

        // Steady-state streaming at level 5 across two pointer wraps.
        push_bytes(5, 8'h80);
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 8'h10 + 8'(i), 1'b1, 1'b0);
            cycle();
            check("stream_level", 32'(level), 32'(5));
        end
        pop_bytes(5);
        check("stream_drained", 32'(level), 32'(0));

        // Flush at level 9 with a simultaneous push and pop.
        push_bytes(9, 8'hA0);
        drive(1'b1, 8'hEE, 1'b1, 1'b1);
        cycle();
        check("flush_level",     32'(level),            32'(0));
        check("flush_out_valid", 32'(bus_if.out_valid), 32'(0));
        check("flush_in_ready",  32'(bus_if.in_ready),  32'(1));
        push_bytes(2, 8'hC0);
        check("post_flush_head", 32'(bus_if.out_data), 32'(8'hC0));
        pop_bytes(2);

        // Reset mid-burst discards stored bytes; in_ready is low during the reset cycle.
        push_bytes(3, 8'hD0);
        reset = 1'b1;
        drive(1'b1, 8'hD9, 1'b1, 1'b0);
        cycle();
        reset = 1'b0;
        check("midreset_level", 32'(level), 32'(0));
        check("midreset_empty", 32'(empty), 32'(1));
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        cycle();

`ifdef UART_TX_FIFO_PEAK_EN
        push_bytes(12, 8'h20);
        pop_bytes(10);
        check("peak_after_12", 32'(peak_level), 32'(12));
        peak_clear = 1'b1;
        cycle();
        peak_clear = 1'b0;
        check("peak_cleared", 32'(peak_level), 32'(2));
        do_reset();
        check("peak_reset", 32'(peak_level), 32'(0));
`endif

        cycle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Byte FIFO between the core's UART transmit request and the Uart transmitter input (in_data/in_valid/in_ready). It decouples core stores to the UART port from the serial bit rate, so short bursts complete without stalling the core. First-word-fall-through, valid/ready on both sides, with a synchronous flush for software or loader restarts.

Parameters:
DEPTH_LOG, 4, log2 of entry count; depth = 2**DEPTH_LOG (16 by default); legal range 1..10
ALMOST_FULL_MARGIN, 2, almost_full asserts when free entries <= this value; must be < 2**DEPTH_LOG

Ports:
clk  input  1  system clock; all state changes on posedge
reset  input  1  synchronous, active-high reset
flush  input  1  synchronous clear of contents; pulse, ignored while reset is high
in_data  input  8  byte from core
in_valid  input  1  core offers in_data
in_ready  output  1  FIFO accepts a byte this cycle
out_data  output  8  head byte to Uart in_data
out_valid  output  1  head byte present, to Uart in_valid
out_ready  input  1  Uart in_ready
level  output  DEPTH_LOG+1  current occupancy, 0..2**DEPTH_LOG
almost_full  output  1  (2**DEPTH_LOG - level) <= ALMOST_FULL_MARGIN
empty  output  1  level == 0

Behaviour:
- Storage: 2**DEPTH_LOG x 8 array. Read pointer and write pointer are each DEPTH_LOG bits and wrap modulo depth. Occupancy is held in a separate DEPTH_LOG+1-bit counter.
- Reset (clk edge with reset=1): pointers=0, level=0, out_valid=0, in_ready=0 during the reset cycle. empty=1, almost_full=0. out_data=8'h00. Array contents are don't-care.
- in_ready = !reset && level < depth. It is combinational from registered state and never depends on in_valid or out_ready.
- out_valid = level != 0. out_data = mem[rd_ptr] (FWFT). out_data holds 8'h00 whenever empty.
- Push: in_valid && in_ready at an edge. Write mem[wr_ptr], then wr_ptr+1.
- Pop: out_valid && out_ready at an edge. rd_ptr+1.
- Level update: push only gives +1; pop only gives -1; push and pop together leave level unchanged and both pointers advance.
- Latency: a byte pushed into an empty FIFO gives out_valid=1 in the next cycle. There is no same-cycle bypass.
- Full: in_ready=0, so a push is impossible. A pop in the same cycle frees an entry, but in_ready only rises in the next cycle.
- Empty: out_valid=0, so a pop is impossible. A push in the same cycle is not forwarded.
- out_data and out_valid stay stable while out_valid=1 and out_ready=0, as Uart requires.
- Flush (edge with flush=1, reset=0): same state as reset except in_ready=1 in the following cycle. Any push or pop in that cycle is discarded. Flush has priority over push and pop.
- Reset mid-burst: all bytes are lost. Neither side may treat in-flight bytes as delivered.
- level, empty and almost_full are registered-state derived. They are valid in the cycle after each edge.

Optional Feature:
UART_TX_FIFO_PEAK_EN — when defined, adds output peak_level [DEPTH_LOG:0] and input peak_clear [1].
- peak_level records the maximum level reached since the last reset, flush or peak_clear.
- Update rule: if next level > peak_level, then peak_level <= next level.
- peak_clear sets peak_level to the current level.
When not defined, neither port exists and there is no extra logic.

Test Plan:
1. Reset, then idle -> in_ready=1, out_valid=0, level=0, empty=1, out_data=8'h00.
2. Push 8'h41 with out_ready=0 -> next cycle out_valid=1, out_data=8'h41, level=1. Raise out_ready for one cycle -> level=0, empty=1.
3. Push 16 bytes 8'h00..8'h0F with out_ready=0 -> level=16, in_ready=0, almost_full asserted from level=14 onward. Hold in_valid with 8'hFF for 3 cycles -> level stays 16 and 8'hFF is never stored. Drain -> output order 8'h00..8'h0F exactly.
4. Hold in_valid=1 and out_ready=1 continuously with level=5 and incrementing data -> level stays 5 for 40 cycles (wrap twice) and output order is preserved.
5. Fill to 9, assert flush together with in_valid and out_ready -> next cycle level=0, out_valid=0, in_ready=1. The flush-cycle byte is absent from later output.
6. With UART_TX_FIFO_PEAK_EN: push 12, pop 10 -> peak_level=12. Pulse peak_clear -> peak_level=2. Reset -> peak_level=0.
